// File: rtl/pl_data_mem_ws.sv
// pl_data_mem_ws: 32-bit data memory with programmable wait states and byte/halfword/word access.
// Define PL_DATA_MEM_MISALIGN_EN to fault misaligned accesses instead of forcing alignment.
module pl_data_mem_ws #(
    parameter int ADDR_W = 5,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    output logic        ready,
    output logic        misalign
);
    localparam int         AW     = ADDR_W + 2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] WAIT_C = 4'(WAIT);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, sext_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   din_q;
    logic [31:0]   dataout_q;
    logic          ready_q, misalign_q;
    logic [31:0]   mem [2**ADDR_W];

    logic          idle, fire;
    logic          op_we, op_sext, is_half, is_word, bad;
    logic [1:0]    op_size;
    logic [AW-1:0] op_addr, ea;
    logic [31:0]   op_din, rdata, ld, wdata;
    logic [3:0]    be;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic          unused_hi;

    assign unused_hi = ^addr[31:AW];
    assign idle      = (state_q == S_IDLE);

    // With WAIT=0 the access completes on its sampling edge, so operands come straight from the ports.
    assign op_we   = idle ? we     : we_q;
    assign op_sext = idle ? sext   : sext_q;
    assign op_size = idle ? size   : size_q;
    assign op_addr = idle ? addr[AW-1:0] : addr_q;
    assign op_din  = idle ? datain : din_q;
    assign is_half = (op_size == 2'b01);
    assign is_word = op_size[1];

`ifdef PL_DATA_MEM_MISALIGN_EN
    assign bad = (is_half && op_addr[0]) || (is_word && (op_addr[1:0] != 2'b00));
    assign ea  = op_addr;
`else
    assign bad = 1'b0;
    assign ea  = {op_addr[AW-1:2], is_word ? 1'b0 : op_addr[1], (is_word || is_half) ? 1'b0 : op_addr[0]};
`endif

    // Counter sits at 0 for one cycle before DONE, giving WAIT+1 cycles of latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            S_IDLE: if (req) begin
                if (WAIT_C == 4'd0) begin
                    state_d = S_DONE;
                    fire    = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_C;
                end
            end
            S_WAIT: if (cnt_q == 4'd0) begin
                state_d = S_DONE;
                fire    = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rdata = mem[ea[AW-1:2]];
    assign rbyte = rdata[{ea[1:0], 3'b000} +: 8];
    assign rhalf = ea[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        if (is_word) begin
            ld    = rdata;
            be    = 4'hF;
            wdata = op_din;
        end else if (is_half) begin
            ld    = {{16{op_sext & rhalf[15]}}, rhalf};
            be    = ea[1] ? 4'b1100 : 4'b0011;
            wdata = {2{op_din[15:0]}};
        end else begin
            ld    = {{24{op_sext & rbyte[7]}}, rbyte};
            be    = 4'b0001 << ea[1:0];
            wdata = {4{op_din[7:0]}};
        end
    end

    // Memory is deliberately outside the reset domain; clr only blocks the write.
    always_ff @(posedge clk) begin
        if (fire && op_we && !bad && !clr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[ea[AW-1:2]][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            sext_q     <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            din_q      <= 32'd0;
            dataout_q  <= 32'd0;
            ready_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= fire;
            misalign_q <= fire & bad;
            if (idle && req) begin
                we_q   <= we;
                sext_q <= sext;
                size_q <= size;
                addr_q <= addr[AW-1:0];
                din_q  <= datain;
            end
            if (fire && !op_we && !bad) dataout_q <= ld;
        end
    end

    assign dataout  = dataout_q;
    assign ready    = ready_q;
    assign misalign = misalign_q;
endmodule

// File: doc/pl_data_mem_ws.md
PL_DATA_MEM_WS -- requirements
Module: pl_data_mem_ws

Interface
REQ-001 SHALL provide parameter ADDR_W, default 5, meaning word-address bits (depth = 2**ADDR_W words of 32 bits).
REQ-002 SHALL provide parameter WAIT, default 2, meaning wait states inserted before each access completes (0..15).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  clock, all state updates on rising edge.
REQ-005 Port: clr  input  1  asynchronous active-high reset.
REQ-006 Port: req  input  1  access request, sampled only in IDLE.
REQ-007 Port: we  input  1  1 = store, 0 = load; sampled with req.
REQ-008 Port: size  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-009 Port: sext  input  1  sign-extend byte/halfword loads when 1, zero-extend when 0.
REQ-010 Port: addr  input  32  byte address; bits above ADDR_W+1 ignored (aliasing).
REQ-011 Port: datain  input  32  store data, right-justified for byte/halfword.
REQ-012 Port: dataout  output  32  load result, registered, valid when ready=1.
REQ-013 Port: ready  output  1  one-cycle completion pulse.
REQ-014 Port: misalign  output  1  one-cycle alignment-fault pulse, coincident with ready.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-016 IDLE: on req=1, latch we, size, sext, addr, datain; load wait counter with WAIT; go WAIT (or DONE directly if WAIT=0).
REQ-017 WAIT: decrement counter each cycle; on counter reaching 0 go DONE.
REQ-018 DONE: perform the write (if we) on this edge, register dataout (if load), assert ready for exactly this cycle, return IDLE.
REQ-019 Latency SHALL be WAIT+1 cycles from the req-sampling edge to the ready cycle; back-to-back requests SHALL be accepted in the cycle after ready.
REQ-020 req while not IDLE SHALL be ignored; latched fields SHALL NOT change mid-access.
REQ-021 Byte lanes little-endian: lane = addr[1:0]; byte store writes only datain[7:0] into that lane; halfword store writes datain[15:0] into lanes {addr[1],0} and {addr[1],1}; word store writes all lanes.
REQ-022 Load SHALL extract the addressed byte/halfword into dataout[7:0]/[15:0], upper bits per sext; word load unmodified.
REQ-023 Store SHALL leave dataout unchanged; unwritten lanes SHALL retain content.
REQ-024 ready SHALL be 0 in IDLE and WAIT.

Reset
REQ-025 clr=1 SHALL immediately force state IDLE, counter 0, dataout 0, ready 0, misalign 0.
REQ-026 clr asserted mid-access SHALL abort it with no memory write; memory contents SHALL NOT be cleared by clr (simulation initial value 0).

Configuration
REQ-027 Macro PL_DATA_MEM_MISALIGN_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL complete with normal latency, misalign=1 with ready, no write, dataout unchanged.
REQ-028 Macro undefined: misalign tied 0; offending low address bits forced to 0 (halfword ignores addr[0], word ignores addr[1:0]) and access proceeds.

Verification
REQ-029 WAIT=2: word store 0x000000A3 to 0x50, then word load 0x50 -> ready exactly 3 cycles after each req, dataout=0x000000A3.
REQ-030 Word 0x80FF7F01 at 0x60: byte loads 0x61 sext=1 -> 0x0000007F; 0x62 sext=1 -> 0xFFFFFFFF; 0x63 sext=0 -> 0x00000080; halfword 0x62 sext=1 -> 0xFFFF80FF.
REQ-031 Word 0x11223344 at 0x70, byte store 0xAB to 0x71, word load -> 0x1122AB44.
REQ-032 Start store 0xDEADBEEF at 0x54, assert clr during WAIT -> ready never pulses, later load 0x54 returns prior value.
REQ-033 With PL_DATA_MEM_MISALIGN_EN: word store to 0x52 -> misalign=1 and ready=1 same cycle, memory unchanged; without macro -> write lands at 0x50.
REQ-034 req held high continuously with WAIT=0 -> one access every 2 cycles, ready alternating 0/1, no extra accesses.
